// File: rtl/test_result_collector_if.sv
// Bundles the harness fail/finish/reset lines and the registered verdict
// so the simulation top can hand one connection to the collector.
interface test_result_collector_if #(
  parameter int NUM_TESTS = 4,
  parameter int IDX_W     = 2,
  parameter int CNT_W     = 16
);
  logic [NUM_TESTS-1:0] fail;
  logic [NUM_TESTS-1:0] finish;
  logic [NUM_TESTS-1:0] test_reset;
  logic                 done;
  logic                 pass;
  logic                 error;
  logic                 timeout;
  logic [IDX_W-1:0]     fail_index;
  logic [CNT_W-1:0]     total_cycles;

  modport master (
    output fail, finish,
    input  test_reset, done, pass, error, timeout, fail_index, total_cycles
  );

  modport slave (
    input  fail, finish,
    output test_reset, done, pass, error, timeout, fail_index, total_cycles
  );
endinterface

// File: rtl/test_result_collector.sv
// Runs the attached harnesses one at a time, watches each for fail/finish or
// a timeout, and reduces the outcome to one sticky, fully registered verdict.
module test_result_collector #(
  parameter int NUM_TESTS      = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 16,
  parameter int IDX_W          = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  test_result_collector_if.slave bus
);
  localparam int RC_W = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {IDLE, RUN, NEXT, PASS, FAIL, TOUT} state_e;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     cur_q, cur_d;
  logic [RC_W-1:0]      run_cnt_q, run_cnt_d;
  logic [NUM_TESTS-1:0] test_reset_q, test_reset_d;
  logic                 done_q, done_d;
  logic                 pass_q, pass_d;
  logic                 error_q, error_d;
  logic                 timeout_q, timeout_d;
  logic [IDX_W-1:0]     fail_index_q, fail_index_d;
  logic [CNT_W-1:0]     total_cycles_q, total_cycles_d;
  logic [IDX_W-1:0]     cur_inc;

  function automatic logic [NUM_TESTS-1:0] release_mask(input logic [IDX_W-1:0] idx);
    logic [NUM_TESTS-1:0] m;
    m      = '1;
    m[idx] = 1'b0;
    return m;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign cur_inc = cur_q + 1'b1;

  always_comb begin
    state_d        = state_q;
    cur_d          = cur_q;
    run_cnt_d      = run_cnt_q;
    test_reset_d   = test_reset_q;
    done_d         = done_q;
    pass_d         = pass_q;
    error_d        = error_q;
    timeout_d      = timeout_q;
    fail_index_d   = fail_index_q;
    total_cycles_d = total_cycles_q;
    case (state_q)
      IDLE: begin
        state_d      = RUN;
        cur_d        = '0;
        run_cnt_d    = '0;
        test_reset_d = release_mask('0);
      end
      RUN: begin
        // The exit cycle counts as a RUN cycle too.
        total_cycles_d = sat_inc(total_cycles_q);
        if (bus.fail[cur_q]) begin
          state_d      = FAIL;
          error_d      = 1'b1;
          fail_index_d = cur_q;
          done_d       = 1'b1;
          test_reset_d = '1;
        end else if (bus.finish[cur_q]) begin
          test_reset_d = '1;
          if (cur_q == IDX_W'(NUM_TESTS - 1)) begin
            state_d = PASS;
            pass_d  = 1'b1;
            done_d  = 1'b1;
          end else begin
            state_d = NEXT;
          end
        end else if (run_cnt_q == RC_W'(TIMEOUT_CYCLES - 1)) begin
          state_d      = TOUT;
          timeout_d    = 1'b1;
          fail_index_d = cur_q;
          done_d       = 1'b1;
          test_reset_d = '1;
        end else begin
          run_cnt_d = run_cnt_q + 1'b1;
        end
      end
      NEXT: begin
        state_d      = RUN;
        cur_d        = cur_inc;
        run_cnt_d    = '0;
        test_reset_d = release_mask(cur_inc);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q        <= IDLE;
      cur_q          <= '0;
      run_cnt_q      <= '0;
      test_reset_q   <= '1;
      done_q         <= 1'b0;
      pass_q         <= 1'b0;
      error_q        <= 1'b0;
      timeout_q      <= 1'b0;
      fail_index_q   <= '0;
      total_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      cur_q          <= cur_d;
      run_cnt_q      <= run_cnt_d;
      test_reset_q   <= test_reset_d;
      done_q         <= done_d;
      pass_q         <= pass_d;
      error_q        <= error_d;
      timeout_q      <= timeout_d;
      fail_index_q   <= fail_index_d;
      total_cycles_q <= total_cycles_d;
    end
  end

  assign bus.test_reset   = test_reset_q;
  assign bus.done         = done_q;
  assign bus.pass         = pass_q;
  assign bus.error        = error_q;
  assign bus.timeout      = timeout_q;
  assign bus.fail_index   = fail_index_q;
  assign bus.total_cycles = total_cycles_q;
endmodule
